fir_bus_master: RTL and testbench

//  I/O-bus initiator driving a dfir128x16x18-style FIR peripheral over its ioaddr/iocs/iowr/iord bus.
//  On cfg_load, writes coefficient address 0 and then the NTAPS coefficients.
//  For each streamed input sample: writes data, issues start, polls status until not busy,

---
 rtl/fir_bus_pkg.sv | 23 ++
 rtl/fir_bus_master.sv | 201 ++++++++++++++++++++
 tb/tb_fir_bus_master.sv | 342 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fir_bus_pkg.sv
// Shared register map and sequencer state encoding for the FIR peripheral bus master.
package fir_bus_pkg;

    localparam logic [2:0] ADDR_DATA = 3'd0;
    localparam logic [2:0] ADDR_CTRL = 3'd2;
    localparam logic [2:0] ADDR_CDAT = 3'd4;
    localparam logic [2:0] ADDR_CADR = 3'd5;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_CADR,
        ST_CDAT,
        ST_DATA,
        ST_START,
        ST_WAIT,
        ST_POLL,
        ST_PGAP,
        ST_RGAP0,
        ST_READ,
        ST_OUT
    } state_t;

endpackage

// File: rtl/fir_bus_master.sv
// Bus initiator that loads FIR coefficients and runs one peripheral computation per streamed sample.
// The state name always describes the bus access (or idle slot) visible on the pins during that cycle.
module fir_bus_master
    import fir_bus_pkg::*;
#(
    parameter int          NTAPS     = 8,
    parameter logic [15:0] CTRL_WORD = 16'h0700,
    parameter int          BUSY_BIT  = 15,
    parameter int          PRE_POLL  = 7,
    parameter int          POLL_MAX  = 255,
    localparam int         IDXW      = (NTAPS > 1) ? $clog2(NTAPS) : 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            cfg_load,
    output logic [IDXW-1:0] coef_idx,
    input  logic [15:0]     coef_data,
    output logic            coef_ok,
    input  logic            s_valid,
    output logic            s_ready,
    input  logic [15:0]     s_data,
    output logic            r_valid,
    input  logic            r_ready,
    output logic [15:0]     r_data,
    output logic [2:0]      ioaddr,
    output logic            iocs,
    output logic            iowr,
    output logic            iord,
    output logic [15:0]     iodout,
    input  logic [15:0]     iodin,
    output logic            busy,
    output logic            timeout,
    input  logic            err_clr
);

    localparam int WCW = (PRE_POLL > 1) ? $clog2(PRE_POLL) : 1;
    localparam int PCW = (POLL_MAX > 1) ? $clog2(POLL_MAX) : 1;

    state_t           state_reg;
    logic             cfg_pend_reg;
    logic [7:0]       coef_cnt_reg;
    logic [WCW-1:0]   wait_cnt_reg;
    logic [PCW-1:0]   poll_cnt_reg;

    // coef_cnt_reg counts coefficients already latched, so it names the next one to fetch.
    assign coef_idx = coef_cnt_reg[IDXW-1:0];
    assign s_ready  = (state_reg == ST_IDLE) && coef_ok && !cfg_pend_reg;
    assign busy     = (state_reg != ST_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= ST_IDLE;
            cfg_pend_reg <= 1'b0;
            coef_cnt_reg <= '0;
            wait_cnt_reg <= '0;
            poll_cnt_reg <= '0;
            coef_ok      <= 1'b0;
            r_valid      <= 1'b0;
            r_data       <= '0;
            ioaddr       <= '0;
            iocs         <= 1'b0;
            iowr         <= 1'b0;
            iord         <= 1'b0;
            iodout       <= '0;
            timeout      <= 1'b0;
        end else begin
            // Bus returns to idle unless the next state issues an access.
            ioaddr       <= '0;
            iocs         <= 1'b0;
            iowr         <= 1'b0;
            iord         <= 1'b0;
            iodout       <= '0;
            cfg_pend_reg <= cfg_pend_reg | cfg_load;
            if (err_clr) begin
                timeout <= 1'b0;
            end

            case (state_reg)
                ST_IDLE: begin
                    if (cfg_pend_reg) begin
                        // A cfg_load arriving in this very cycle stays pending for another pass.
                        cfg_pend_reg <= cfg_load;
                        coef_ok      <= 1'b0;
                        coef_cnt_reg <= '0;
                        ioaddr       <= ADDR_CADR;
                        iocs         <= 1'b1;
                        iowr         <= 1'b1;
                        iodout       <= '0;
                        state_reg    <= ST_CADR;
                    end else if (coef_ok && s_valid) begin
                        ioaddr    <= ADDR_DATA;
                        iocs      <= 1'b1;
                        iowr      <= 1'b1;
                        iodout    <= s_data;
                        state_reg <= ST_DATA;
                    end
                end

                ST_CADR: begin
                    ioaddr       <= ADDR_CDAT;
                    iocs         <= 1'b1;
                    iowr         <= 1'b1;
                    iodout       <= coef_data;
                    coef_cnt_reg <= coef_cnt_reg + 8'd1;
                    state_reg    <= ST_CDAT;
                end

                ST_CDAT: begin
                    if (coef_cnt_reg == 8'(NTAPS)) begin
                        coef_ok   <= 1'b1;
                        state_reg <= ST_IDLE;
                    end else begin
                        ioaddr       <= ADDR_CDAT;
                        iocs         <= 1'b1;
                        iowr         <= 1'b1;
                        iodout       <= coef_data;
                        coef_cnt_reg <= coef_cnt_reg + 8'd1;
                    end
                end

                ST_DATA: begin
                    ioaddr    <= ADDR_CTRL;
                    iocs      <= 1'b1;
                    iowr      <= 1'b1;
                    iodout    <= CTRL_WORD;
                    state_reg <= ST_START;
                end

                ST_START: begin
                    wait_cnt_reg <= '0;
                    poll_cnt_reg <= '0;
                    if (PRE_POLL == 0) begin
                        ioaddr    <= ADDR_CTRL;
                        iocs      <= 1'b1;
                        iord      <= 1'b1;
                        state_reg <= ST_POLL;
                    end else begin
                        state_reg <= ST_WAIT;
                    end
                end

                ST_WAIT: begin
                    if (wait_cnt_reg == WCW'(PRE_POLL - 1)) begin
                        ioaddr    <= ADDR_CTRL;
                        iocs      <= 1'b1;
                        iord      <= 1'b1;
                        state_reg <= ST_POLL;
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg + 1'b1;
                    end
                end

                ST_POLL: begin
                    if (iodin[BUSY_BIT]) begin
                        if (poll_cnt_reg == PCW'(POLL_MAX - 1)) begin
                            timeout   <= 1'b1;
                            state_reg <= ST_IDLE;
                        end else begin
                            poll_cnt_reg <= poll_cnt_reg + 1'b1;
                            state_reg    <= ST_PGAP;
                        end
                    end else begin
                        state_reg <= ST_RGAP0;
                    end
                end

                ST_PGAP: begin
                    ioaddr    <= ADDR_CTRL;
                    iocs      <= 1'b1;
                    iord      <= 1'b1;
                    state_reg <= ST_POLL;
                end

                ST_RGAP0: begin
                    ioaddr    <= ADDR_DATA;
                    iocs      <= 1'b1;
                    iord      <= 1'b1;
                    state_reg <= ST_READ;
                end

                ST_READ: begin
                    r_data    <= iodin;
                    r_valid   <= 1'b1;
                    state_reg <= ST_OUT;
                end

                ST_OUT: begin
                    if (r_ready) begin
                        r_valid   <= 1'b0;
                        state_reg <= ST_IDLE;
                    end
                end

                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fir_bus_master.sv
// Directed bench for fir_bus_master with a behavioural FIR peripheral whose busy time is adjustable.
module tb_fir_bus_master;

    logic        clk;
    logic        rst_n;
    logic        cfg_load;
    logic [2:0]  coef_idx;
    logic [15:0] coef_data;
    logic        coef_ok;
    logic        s_valid;
    logic        s_ready;
    logic [15:0] s_data;
    logic        r_valid;
    logic        r_ready;
    logic [15:0] r_data;
    logic [2:0]  ioaddr;
    logic        iocs;
    logic        iowr;
    logic        iord;
    logic [15:0] iodout;
    logic [15:0] iodin;
    logic        busy;
    logic        timeout;
    logic        err_clr;

    fir_bus_master dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cfg_load  (cfg_load),
        .coef_idx  (coef_idx),
        .coef_data (coef_data),
        .coef_ok   (coef_ok),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
        .r_valid   (r_valid),
        .r_ready   (r_ready),
        .r_data    (r_data),
        .ioaddr    (ioaddr),
        .iocs      (iocs),
        .iowr      (iowr),
        .iord      (iord),
        .iodout    (iodout),
        .iodin     (iodin),
        .busy      (busy),
        .timeout   (timeout),
        .err_clr   (err_clr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    localparam logic [15:0] COEFS   [8] = '{16'd2048, 16'd4096, 16'd8192, 16'd16384,
                                            16'd8192, 16'd4096, 16'd2048, 16'd0};
    localparam logic [15:0] IMP_EXP [8] = '{16'd1024, 16'd2048, 16'd4096, 16'd8192,
                                            16'd4096, 16'd2048, 16'd1024, 16'd0};

    assign coef_data = COEFS[coef_idx];

    // ---------------- peripheral model and bus monitor ----------------
    logic signed [15:0] cmem [8] = '{default: 16'sd0};
    logic signed [15:0] xd   [8] = '{default: 16'sd0};
    logic [2:0]  cptr = 3'd0;
    int          busy_left = 0;
    int          busy_polls = 0;
    logic [15:0] result = 16'd0;
    longint      acc_v;
    logic [15:0] model_y;

    int cyc = 0;
    int n_poll = 0;
    int n_rdata = 0;
    int nbus = 0;
    int gap_err = 0;
    int force_err = 0;
    int strobe_err = 0;
    logic prev_rd = 1'b0;
    logic [2:0]  wr_addr [$];
    logic [15:0] wr_data [$];
    int          wr_cyc  [$];
    int          poll_cyc [$];

    always_comb begin
        acc_v = 0;
        for (int k = 0; k < 8; k++) begin
            acc_v = acc_v + longint'(cmem[k]) * longint'(xd[k]);
        end
        model_y = 16'(acc_v >>> 15);
    end

    assign iodin = (iocs && iord) ? ((ioaddr == 3'd2) ? {(busy_left != 0), 15'd0} : result) : 16'd0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (iocs && iowr) begin
            wr_addr.push_back(ioaddr);
            wr_data.push_back(iodout);
            wr_cyc.push_back(cyc);
            nbus <= nbus + 1;
            case (ioaddr)
                3'd5: cptr <= iodout[2:0];
                3'd4: begin
                    cmem[cptr] <= iodout;
                    cptr <= cptr + 3'd1;
                end
                3'd0: begin
                    for (int k = 7; k > 0; k--) xd[k] <= xd[k-1];
                    xd[0] <= iodout;
                end
                3'd2: begin
                    result    <= model_y;
                    busy_left <= busy_polls;
                end
                default: ;
            endcase
        end
        if (iocs && iord) begin
            nbus <= nbus + 1;
            if (ioaddr == 3'd2) begin
                n_poll <= n_poll + 1;
                poll_cyc.push_back(cyc);
                if (busy_left > 0) busy_left <= busy_left - 1;
            end else begin
                n_rdata <= n_rdata + 1;
            end
        end
        if (prev_rd && iocs) gap_err <= gap_err + 1;
        prev_rd <= iocs && iord;
        if (!iocs && (iowr || iord || ioaddr != 3'd0 || iodout != 16'd0)) force_err <= force_err + 1;
        if (iocs && (iowr == iord)) strobe_err <= strobe_err + 1;
    end

    // ---------------- checking ----------------
    int total = 0;
    int bad = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [15:0] x);
        int n;
        n = 0;
        while (!s_ready && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        check_val("s_ready_wait", 32'(s_ready), 1);
        s_valid = 1'b1;
        s_data  = x;
        @(posedge clk); #1;
        s_valid = 1'b0;
    endtask

    task automatic get_result(output int lat);
        lat = 0;
        while (!r_valid && lat < 3000) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic load_coefs(input string tag);
        int n;
        cfg_load = 1'b1;
        @(posedge clk); #1;
        cfg_load = 1'b0;
        n = 0;
        while (!coef_ok && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check_val(tag, 32'(coef_ok), 1);
    endtask

    initial begin
        int lat, wb, pb, rb, bb, seen, chg;
        logic [15:0] hold;
        logic [15:0] x;

        rst_n = 1'b1; cfg_load = 1'b0; s_valid = 1'b0; s_data = 16'd0;
        r_ready = 1'b1; err_clr = 1'b0;
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_iocs",    32'(iocs), 0);
        check_val("rst_s_ready", 32'(s_ready), 0);
        check_val("rst_coef_ok", 32'(coef_ok), 0);
        check_val("rst_r_valid", 32'(r_valid), 0);
        check_val("rst_busy",    32'(busy), 0);
        check_val("rst_timeout", 32'(timeout), 0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // 1: coefficient load
        wb = wr_addr.size();
        load_coefs("cfg_done");
        check_val("cfg_nwrites", 32'(wr_addr.size() - wb), 9);
        check_val("cadr_addr", 32'(wr_addr[wb]), 5);
        check_val("cadr_data", 32'(wr_data[wb]), 0);
        for (int k = 0; k < 8; k++) begin
            check_val("cdat_addr", 32'(wr_addr[wb+1+k]), 4);
            check_val("cdat_data", 32'(wr_data[wb+1+k]), 32'(COEFS[k]));
        end
        check_val("cdat_b2b", 32'(wr_cyc[wb+8] - wr_cyc[wb+1]), 7);
        $display("cfg load: %0d writes, coef_ok=%0d", wr_addr.size() - wb, coef_ok);

        // 2: impulse response
        for (int i = 0; i < 8; i++) begin
            x  = (i == 0) ? 16'd16384 : 16'd0;
            wb = wr_addr.size();
            pb = poll_cyc.size();
            rb = n_rdata;
            send(x);
            get_result(lat);
            check_val("imp_r_data", 32'(r_data), 32'(IMP_EXP[i]));
            check_val("imp_latency", 32'(lat), 12);
            if (i == 0) begin
                check_val("imp_wr0_addr", 32'(wr_addr[wb]), 0);
                check_val("imp_wr0_data", 32'(wr_data[wb]), 16384);
                check_val("imp_wr1_addr", 32'(wr_addr[wb+1]), 2);
                check_val("imp_wr1_data", 32'(wr_data[wb+1]), 32'h0700);
                check_val("imp_prepoll", 32'(poll_cyc[pb] - wr_cyc[wb+1]), 8);
                check_val("imp_nread",   32'(n_rdata - rb), 1);
            end
            $display("impulse sample %0d in=%0d out=%0d latency=%0d", i, x, r_data, lat);
        end

        // 3: three busy polls
        busy_polls = 3;
        pb = n_poll;
        send(16'd16384);
        get_result(lat);
        check_val("busy3_r_data", 32'(r_data), 1024);
        check_val("busy3_latency", 32'(lat), 18);
        check_val("busy3_polls", 32'(n_poll - pb), 4);
        $display("busy3 sample out=%0d latency=%0d polls=%0d", r_data, lat, n_poll - pb);

        // 4: stuck busy -> timeout
        busy_polls = 100000;
        pb = n_poll;
        seen = 0;
        send(16'd0);
        lat = 0;
        while (!timeout && lat < 2000) begin
            @(posedge clk); #1;
            lat++;
            if (r_valid) seen++;
        end
        check_val("to_flag", 32'(timeout), 1);
        check_val("to_polls", 32'(n_poll - pb), 255);
        check_val("to_no_rvalid", 32'(seen), 0);
        check_val("to_s_ready", 32'(s_ready), 1);
        busy_polls = 0;
        err_clr = 1'b1;
        @(posedge clk); #1;
        err_clr = 1'b0;
        check_val("to_cleared", 32'(timeout), 0);
        $display("timeout sample polls=%0d timeout_cleared=%0d", n_poll - pb, !timeout);

        // 5: backpressure in OUT
        r_ready = 1'b0;
        send(16'h8000);
        get_result(lat);
        check_val("bp_latency", 32'(lat), 12);
        check_val("bp_r_data", 32'(r_data), 2048);
        hold = r_data;
        bb = nbus;
        seen = 0;
        chg = 0;
        repeat (10) begin
            @(posedge clk); #1;
            if (r_data !== hold || !r_valid) chg++;
            if (s_ready) seen++;
        end
        check_val("bp_stable", 32'(chg), 0);
        check_val("bp_no_bus", 32'(nbus - bb), 0);
        check_val("bp_s_ready", 32'(seen), 0);
        r_ready = 1'b1;
        @(posedge clk); #1;
        check_val("bp_released", 32'(r_valid), 0);
        $display("backpressure sample out=%0d held 10 cycles", hold);

        // 6: reset during POLL
        busy_polls = 50;
        send(16'd7);
        lat = 0;
        while (!(iocs && iord && ioaddr == 3'd2) && lat < 300) begin
            @(posedge clk); #1;
            lat++;
        end
        check_val("rst6_in_poll", 32'(iocs && iord), 1);
        #2 rst_n = 1'b0;
        #1;
        check_val("rst6_iocs", 32'(iocs), 0);
        check_val("rst6_iord", 32'(iord), 0);
        check_val("rst6_coef_ok", 32'(coef_ok), 0);
        check_val("rst6_busy", 32'(busy), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        busy_polls = 0;
        seen = 0;
        repeat (5) begin
            @(posedge clk); #1;
            if (s_ready) seen++;
        end
        cfg_load = 1'b1;
        @(posedge clk); #1;
        cfg_load = 1'b0;
        lat = 0;
        while (!coef_ok && lat < 100) begin
            if (s_ready) seen++;
            @(posedge clk); #1;
            lat++;
        end
        check_val("rst6_no_ready", 32'(seen), 0);
        check_val("rst6_reload", 32'(coef_ok), 1);
        check_val("rst6_ready_back", 32'(s_ready), 1);
        send(16'd0);
        get_result(lat);
        check_val("rst6_r_data", 32'(r_data), 32'hF000);
        check_val("rst6_latency", 32'(lat), 12);
        $display("post-reset sample out=0x%0h latency=%0d", r_data, lat);

        repeat (3) @(posedge clk);
        #1;
        check_val("gap_after_read", 32'(gap_err), 0);
        check_val("idle_bus_zero", 32'(force_err), 0);
        check_val("one_strobe", 32'(strobe_err), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
